// File: rtl/alu_multiciclo.sv
// alu_multiciclo: WIDTH-bit ALU with a valid/ready handshake.
// Logic, shift, add/sub, compare and branch ops finish in one cycle.
// MUL (shift-add) and DIVU/REMU (restoring division) iterate for WIDTH cycles.
// All outputs come from registers.
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             entrada_valida,
    output logic             pronta,
    input  logic [3:0]       operacao,
    input  logic [WIDTH-1:0] valor_reg1,
    input  logic [WIDTH-1:0] valor_reg2,
    input  logic [WIDTH-1:0] imediato,
    input  logic             ALUSrc,
    output logic [WIDTH-1:0] resultado_alu,
    output logic             resultado_valido,
    output logic             resultado_desvio,
    output logic             op_invalida
);

    typedef enum logic [1:0] {OCIOSA, MULT, DIV} estado_t;

    estado_t                  estado, prox_estado;
    logic [SHW-1:0]           contador;
    logic                     ultimo;
    logic                     aceita;
    logic                     op_iterativa;
    logic [WIDTH-1:0]         operando_b;
    logic signed [WIDTH-1:0]  a_s, b_s;
    logic [SHW-1:0]           sh;

    logic [WIDTH-1:0]         res_simples;
    logic                     desvio_simples;
    logic                     invalida_simples;

    // Iterative datapath: op_a is multiplicand or dividend/quotient,
    // op_b is multiplier or divisor, acc is product or partial remainder.
    logic [WIDTH-1:0]         op_a, op_b, acc;
    logic                     eh_rem;
    logic [WIDTH-1:0]         mul_prox;
    logic [WIDTH:0]           r_desl;
    logic                     cabe;
    logic [WIDTH-1:0]         rem_prox, quo_prox;

    assign operando_b   = ALUSrc ? imediato : valor_reg2;
    assign a_s          = valor_reg1;
    assign b_s          = operando_b;
    assign sh           = operando_b[SHW-1:0];
    assign pronta       = (estado == OCIOSA);
    assign aceita       = entrada_valida && pronta;
    assign op_iterativa = (operacao == 4'b1100) || (operacao == 4'b1101) || (operacao == 4'b1110);
    assign ultimo       = (contador == SHW'(WIDTH - 1));

    // Shift-add step and restoring-division step; a zero divisor always
    // "fits", which yields an all-ones quotient and the dividend as remainder.
    assign mul_prox = acc + (op_b[0] ? op_a : '0);
    assign r_desl   = {acc, op_a[WIDTH-1]};
    assign cabe     = (r_desl >= {1'b0, op_b});
    assign rem_prox = cabe ? WIDTH'(r_desl - {1'b0, op_b}) : r_desl[WIDTH-1:0];
    assign quo_prox = {op_a[WIDTH-2:0], cabe};

    // Single-cycle result, computed from the operands present at the accept edge.
    always_comb begin
        res_simples      = '0;
        desvio_simples   = 1'b0;
        invalida_simples = 1'b0;
        case (operacao)
            4'b0000: res_simples = valor_reg1 & operando_b;
            4'b0001: res_simples = valor_reg1 | operando_b;
            4'b0010: res_simples = valor_reg1 + operando_b;
            4'b0011: res_simples = valor_reg1 << sh;
            4'b0100: res_simples = valor_reg1 ^ operando_b;
            4'b0101: res_simples = valor_reg1 >> sh;
            4'b1000: res_simples = a_s >>> sh;
            4'b0110: begin
                res_simples    = valor_reg1 - operando_b;
                desvio_simples = (valor_reg1 != operando_b);
            end
            4'b0111: res_simples = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'b1001: res_simples = {{(WIDTH-1){1'b0}}, (valor_reg1 < operando_b)};
            4'b1010: begin
                res_simples    = valor_reg1 - operando_b;
                desvio_simples = (valor_reg1 == operando_b);
            end
            4'b1011: begin
                res_simples    = valor_reg1 - operando_b;
                desvio_simples = (a_s < b_s);
            end
            4'b1111: invalida_simples = 1'b1;
            default: res_simples = '0;
        endcase
    end

    // Next-state logic: leave OCIOSA only for iterative ops, return after WIDTH steps.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSA: begin
                if (aceita && operacao == 4'b1100) begin
                    prox_estado = MULT;
                end else if (aceita && op_iterativa) begin
                    prox_estado = DIV;
                end
            end
            MULT, DIV: begin
                if (ultimo) begin
                    prox_estado = OCIOSA;
                end
            end
            default: prox_estado = OCIOSA;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= OCIOSA;
            contador <= '0;
        end else begin
            estado <= prox_estado;
            if (estado != OCIOSA && !ultimo) begin
                contador <= contador + 1'b1;
            end else begin
                contador <= '0;
            end
        end
    end

    // Iterative datapath registers; no reset needed, they are loaded on accept.
    always_ff @(posedge clock) begin
        if (estado == OCIOSA && aceita) begin
            op_a   <= valor_reg1;
            op_b   <= operando_b;
            acc    <= '0;
            eh_rem <= (operacao == 4'b1110);
        end else if (estado == MULT) begin
            acc  <= mul_prox;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
        end else if (estado == DIV) begin
            acc  <= rem_prox;
            op_a <= quo_prox;
        end
    end

    // Output registers: a one-cycle pulse per completion, values held otherwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            resultado_alu    <= '0;
            resultado_valido <= 1'b0;
            resultado_desvio <= 1'b0;
            op_invalida      <= 1'b0;
        end else begin
            resultado_valido <= 1'b0;
            op_invalida      <= 1'b0;
            if (estado == OCIOSA && aceita && !op_iterativa) begin
                resultado_alu    <= res_simples;
                resultado_desvio <= desvio_simples;
                op_invalida      <= invalida_simples;
                resultado_valido <= 1'b1;
            end else if (estado == MULT && ultimo) begin
                resultado_alu    <= mul_prox;
                resultado_desvio <= 1'b0;
                resultado_valido <= 1'b1;
            end else if (estado == DIV && ultimo) begin
                resultado_alu    <= eh_rem ? rem_prox : quo_prox;
                resultado_desvio <= 1'b0;
                resultado_valido <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Testbench for alu_multiciclo (WIDTH=32): directed scenarios plus random
// operations checked against a behavioural reference model.
module tb_alu_multiciclo;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          entrada_valida;
    logic          pronta;
    logic [3:0]    operacao;
    logic [W-1:0]  valor_reg1;
    logic [W-1:0]  valor_reg2;
    logic [W-1:0]  imediato;
    logic          ALUSrc;
    logic [W-1:0]  resultado_alu;
    logic          resultado_valido;
    logic          resultado_desvio;
    logic          op_invalida;

    int checks = 0;
    int errors = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .entrada_valida   (entrada_valida),
        .pronta           (pronta),
        .operacao         (operacao),
        .valor_reg1       (valor_reg1),
        .valor_reg2       (valor_reg2),
        .imediato         (imediato),
        .ALUSrc           (ALUSrc),
        .resultado_alu    (resultado_alu),
        .resultado_valido (resultado_valido),
        .resultado_desvio (resultado_desvio),
        .op_invalida      (op_invalida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference behaviour written with plain arithmetic operators.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic d, output logic inv);
        int sh;
        logic signed [W-1:0] sa;
        sh  = int'(b % W);
        sa  = a;
        r   = '0;
        d   = 1'b0;
        inv = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a << sh;
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  begin r = a - b; d = (a != b); end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = sa >>> sh;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin r = a - b; d = (a == b); end
            4'd11: begin r = a - b; d = ($signed(a) < $signed(b)); end
            4'd12: r = a * b;
            4'd13: r = (b == 0) ? '1 : a / b;
            4'd14: r = (b == 0) ? a : a % b;
            default: inv = 1'b1;
        endcase
    endfunction

    function automatic int latencia(input logic [3:0] op);
        return (op >= 4'd12 && op <= 4'd14) ? 33 : 1;
    endfunction

    // Issues one request and waits (bounded) for its completion pulse.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b2,
                          input logic [W-1:0] imm, input logic src,
                          output logic [W-1:0] res, output logic desv, output logic inv, output int lat);
        @(negedge clock);
        operacao       = op;
        valor_reg1     = a;
        valor_reg2     = b2;
        imediato       = imm;
        ALUSrc         = src;
        entrada_valida = 1'b1;
        @(posedge clock);
        #1;
        entrada_valida = 1'b0;
        lat = 1;
        while (!resultado_valido && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        res  = resultado_alu;
        desv = resultado_desvio;
        inv  = op_invalida;
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        entrada_valida = 1'b0;
        operacao       = 4'd0;
        valor_reg1     = '0;
        valor_reg2     = '0;
        imediato       = '0;
        ALUSrc         = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({resultado_alu, resultado_valido, resultado_desvio, op_invalida} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got alu=%h vld=%b desv=%b inv=%b, want all 0",
                     resultado_alu, resultado_valido, resultado_desvio, op_invalida);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (pronta !== 1'b1 || resultado_valido !== 1'b0) begin
            errors++;
            $display("FAIL reset_pronta: got pronta=%b vld=%b, want 1/0", pronta, resultado_valido);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops [3] = '{4'b0010, 4'b0110, 4'b1000};
        logic [W-1:0] as  [3] = '{32'd5, 32'd9, 32'h8000_0000};
        logic [W-1:0] bs  [3] = '{32'd7, 32'd9, 32'd4};
        logic [W-1:0] er  [3] = '{32'd12, 32'd0, 32'hF800_0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            operacao       = ops[i];
            valor_reg1     = as[i];
            valor_reg2     = bs[i];
            ALUSrc         = 1'b0;
            entrada_valida = 1'b1;
            checks++;
            if (pronta !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pronta[%0d]: got %b, want 1", i, pronta);
            end
            @(posedge clock);
            #1;
            checks++;
            if (resultado_valido !== 1'b1 || resultado_alu !== er[i] || resultado_desvio !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got vld=%b res=%h desv=%b, want 1/%h/0",
                         i, resultado_valido, resultado_alu, resultado_desvio, er[i]);
            end
        end
        @(negedge clock);
        entrada_valida = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (resultado_valido !== 1'b0 || resultado_alu !== 32'hF800_0000) begin
            errors++;
            $display("FAIL b2b_hold: got vld=%b res=%h, want 0/f8000000", resultado_valido, resultado_alu);
        end
    endtask

    task automatic test_mul_busy;
        logic [W-1:0] er;
        logic         ed, ei;
        logic [W-1:0] ra, rb;
        @(negedge clock);
        operacao       = 4'b1100;
        valor_reg1     = 32'd7;
        valor_reg2     = 32'hFFFF_FFFD;
        ALUSrc         = 1'b0;
        entrada_valida = 1'b1;
        @(posedge clock);
        #1;
        // Busy window: new requests and changed operands must have no effect.
        for (int k = 1; k <= 32; k++) begin
            checks++;
            if (pronta !== 1'b0 || resultado_valido !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy[%0d]: got pronta=%b vld=%b, want 0/0", k, pronta, resultado_valido);
            end
            ra             = $urandom;
            rb             = $urandom;
            operacao       = 4'b0010;
            valor_reg1     = ra;
            valor_reg2     = rb;
            entrada_valida = 1'b1;
            @(posedge clock);
            #1;
        end
        checks++;
        if (resultado_valido !== 1'b1 || pronta !== 1'b1 || resultado_alu !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result: got vld=%b pronta=%b res=%h, want 1/1/ffffffeb",
                     resultado_valido, pronta, resultado_alu);
        end
        // The pending ADD is accepted in the same cycle as the MUL pulse.
        model(4'b0010, ra, rb, er, ed, ei);
        @(posedge clock);
        #1;
        entrada_valida = 1'b0;
        checks++;
        if (resultado_valido !== 1'b1 || resultado_alu !== er) begin
            errors++;
            $display("FAIL mul_then_add: got vld=%b res=%h, want 1/%h", resultado_valido, resultado_alu, er);
        end
    endtask

    task automatic test_div;
        logic [3:0]   ops [4] = '{4'b1101, 4'b1110, 4'b1101, 4'b1110};
        logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'h1234, 32'h1234};
        logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
        logic [W-1:0] er  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
        logic [W-1:0] r;
        logic         d, inv;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 32'h0, 1'b0, r, d, inv, lat);
            checks++;
            if (r !== er[i] || lat != 33 || d !== 1'b0 || inv !== 1'b0) begin
                errors++;
                $display("FAIL div[%0d]: got res=%h lat=%0d desv=%b inv=%b, want %h/33/0/0",
                         i, r, lat, d, inv, er[i]);
            end
        end
    endtask

    task automatic test_imediato;
        logic [3:0]   ops [4] = '{4'b0010, 4'b1011, 4'b1001, 4'b1111};
        logic [W-1:0] as  [4] = '{32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h55};
        logic [W-1:0] im  [4] = '{32'hFFFF_FFF0, 32'd1, 32'd1, 32'h66};
        logic [W-1:0] er  [4] = '{32'd0, 32'hFFFF_FFFE, 32'd0, 32'd0};
        logic         ed  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         ei  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] r;
        logic         d, inv;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], 32'h0BAD_0BAD, im[i], 1'b1, r, d, inv, lat);
            checks++;
            if (r !== er[i] || d !== ed[i] || inv !== ei[i] || lat != 1) begin
                errors++;
                $display("FAIL imm[%0d]: got res=%h desv=%b inv=%b lat=%0d, want %h/%b/%b/1",
                         i, r, d, inv, lat, er[i], ed[i], ei[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        logic [W-1:0] r;
        logic         d, inv;
        int           lat;
        int           pulsos;
        @(negedge clock);
        operacao       = 4'b1100;
        valor_reg1     = 32'd3;
        valor_reg2     = 32'd5;
        ALUSrc         = 1'b0;
        entrada_valida = 1'b1;
        @(posedge clock);
        #1;
        entrada_valida = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({resultado_alu, resultado_valido, resultado_desvio, op_invalida} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got alu=%h vld=%b desv=%b inv=%b, want all 0",
                     resultado_alu, resultado_valido, resultado_desvio, op_invalida);
        end
        @(negedge clock);
        reset = 1'b1;
        pulsos = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (resultado_valido === 1'b1) pulsos++;
        end
        checks++;
        if (pulsos != 0 || pronta !== 1'b1) begin
            errors++;
            $display("FAIL midreset_no_pulse: got pulses=%0d pronta=%b, want 0/1", pulsos, pronta);
        end
        run_op(4'b0010, 32'd1, 32'd1, 32'h0, 1'b0, r, d, inv, lat);
        checks++;
        if (r !== 32'd2 || lat != 1) begin
            errors++;
            $display("FAIL midreset_add: got res=%h lat=%0d, want 2/1", r, lat);
        end
    endtask

    task automatic test_random;
        logic [3:0]   op;
        logic [W-1:0] a, b2, imm, bsel, r, er;
        logic         src, d, inv, ed, ei;
        int           lat;
        for (int i = 0; i < 60; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = $urandom;
            b2   = $urandom;
            imm  = $urandom;
            src  = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b2 = 32'($urandom_range(0, 9));
                1: imm = 32'($urandom_range(0, 9));
                2: a = b2;
                default: ;
            endcase
            bsel = src ? imm : b2;
            model(op, a, bsel, er, ed, ei);
            run_op(op, a, b2, imm, src, r, d, inv, lat);
            checks++;
            if (r !== er || d !== ed || inv !== ei || lat != latencia(op)) begin
                errors++;
                $display("FAIL rand[%0d] op=%h a=%h b=%h: got res=%h desv=%b inv=%b lat=%0d, want %h/%b/%b/%0d",
                         i, op, a, bsel, r, d, inv, lat, er, ed, ei, latencia(op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul_busy();
        test_div();
        test_imediato();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
